// File: rtl/freqchng_ctrl.sv
// freqchng_ctrl: walks the two-stage clock-mux select one bit at a time with settle waits.
// Define FREQCHNG_CTRL_LOCK_EN to add the LOCK input that blocks new requests.
module freqchng_ctrl #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_VALID,
    input  logic [2:0] REQ_FREQ,
`ifdef FREQCHNG_CTRL_LOCK_EN
    input  logic       LOCK,
`endif
    output logic       REQ_READY,
    output logic [2:0] FREQ_SEL,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    typedef enum logic [2:0] {
        IDLE,
        SW_LO,
        WAIT_LO,
        SW_HI,
        WAIT_HI,
        FIN
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic       tgt_hi_q, tgt_hi_d;
    logic       err_q, err_d;

    logic       lock;
    logic       accept;
    logic       req_legal;
    logic [1:0] req_tgt;

`ifdef FREQCHNG_CTRL_LOCK_EN
    assign lock = LOCK;
`else
    assign lock = 1'b0;
`endif

    assign REQ_READY = (state_q == IDLE) & ~RST & ~lock;
    assign accept    = REQ_READY & REQ_VALID;
    assign req_legal = (REQ_FREQ <= 3'd2);

    // Index 2 only needs the second stage; the first-stage bit is kept.
    always_comb begin
        req_tgt = 2'b00;
        if (REQ_FREQ == 3'd1) begin
            req_tgt = 2'b01;
        end else if (REQ_FREQ == 3'd2) begin
            req_tgt = {1'b1, sel_q[0]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            sel_q    <= 2'b00;
            cnt_q    <= 8'd0;
            tgt_hi_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            tgt_hi_q <= tgt_hi_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        tgt_hi_d = tgt_hi_q;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_legal) begin
                        err_d = 1'b1;
                    end else begin
                        tgt_hi_d = req_tgt[1];
                        if (req_tgt[0] != sel_q[0]) begin
                            sel_d[0] = req_tgt[0];
                            cnt_d    = CNT_LOAD;
                            state_d  = SW_LO;
                        end else if (req_tgt[1] != sel_q[1]) begin
                            sel_d[1] = req_tgt[1];
                            cnt_d    = CNT_LOAD;
                            state_d  = SW_HI;
                        end else begin
                            state_d = FIN;
                        end
                    end
                end
            end
            SW_LO, WAIT_LO: begin
                if (cnt_q != 8'd0) begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = WAIT_LO;
                end else if (tgt_hi_q != sel_q[1]) begin
                    sel_d[1] = tgt_hi_q;
                    cnt_d    = CNT_LOAD;
                    state_d  = SW_HI;
                end else begin
                    state_d = FIN;
                end
            end
            SW_HI, WAIT_HI: begin
                if (cnt_q != 8'd0) begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = WAIT_HI;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign FREQ_SEL = {1'b0, sel_q};
    assign BUSY     = (state_q != IDLE);
    assign DONE     = (state_q == FIN);
    assign ERR      = err_q;

endmodule
